// File: rtl/zion_rvi_addsub_resolve_stage.sv
// rtl/zion_rvi_addsub_resolve_stage.sv - add/sub result resolve stage: writeback or branch decision
// Output register plus one skid entry keeps in_rdy fully registered toward the execute unit.
module zion_rvi_addsub_resolve_stage #(
   parameter int XLEN      = 32,
   parameter int REG_IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [2:0]           in_op,
   input  logic [XLEN-1:0]      in_rslt,
   input  logic                 in_lt,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [XLEN-1:0]      in_imm,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic                 wb_en,
   output logic [REG_IDX_W-1:0] wb_rd,
   output logic [XLEN-1:0]      wb_data,
   output logic                 br_vld,
   output logic                 br_taken,
   output logic [XLEN-1:0]      br_target,
   output logic                 redirect
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_SLT  = 3'd2;
   localparam logic [2:0] OP_SLTU = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_BNE  = 3'd5;
   localparam logic [2:0] OP_BLT  = 3'd6;
   localparam logic [2:0] OP_BGE  = 3'd7;

   typedef struct packed {
      logic                 wb_en;
      logic [REG_IDX_W-1:0] wb_rd;
      logic [XLEN-1:0]      wb_data;
      logic                 br_vld;
      logic                 br_taken;
      logic [XLEN-1:0]      br_target;
   } entry_t;

   entry_t res;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_vld_q, out_vld_d;
   logic   skid_vld_q, skid_vld_d;
   logic   in_rdy_q, in_rdy_d;
   logic   accept;
   logic   out_free;
   logic   rslt_eq;

   // Resolve on the input side so both buffer slots hold final values.
   always_comb begin
      res           = '0;
      rslt_eq       = (in_rslt == '0);
      res.wb_rd     = in_rd;
      res.br_target = in_pc + in_imm;
      case (in_op)
         OP_ADD, OP_SUB: begin
            res.wb_data = in_rslt;
            res.wb_en   = (in_rd != '0);
         end
         OP_SLT, OP_SLTU: begin
            res.wb_data = {{(XLEN-1){1'b0}}, in_lt};
            res.wb_en   = (in_rd != '0);
         end
         OP_BEQ: begin
            res.br_vld   = 1'b1;
            res.br_taken = rslt_eq;
         end
         OP_BNE: begin
            res.br_vld   = 1'b1;
            res.br_taken = !rslt_eq;
         end
         OP_BLT: begin
            res.br_vld   = 1'b1;
            res.br_taken = in_lt;
         end
         OP_BGE: begin
            res.br_vld   = 1'b1;
            res.br_taken = !in_lt;
         end
         default: res = '0;
      endcase
   end

   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      accept     = in_vld && in_rdy_q;
      out_free   = !out_vld_q || out_rdy;

      if (out_free) begin
         if (skid_vld_q) begin
            // Skid moves forward; a same-cycle accept refills it behind.
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = accept;
            if (accept) begin
               skid_d = res;
            end
         end else begin
            out_vld_d = accept;
            out_d     = accept ? res : '0;
         end
      end else if (accept) begin
         skid_d     = res;
         skid_vld_d = 1'b1;
      end

      if (flush) begin
         out_d      = '0;
         out_vld_d  = 1'b0;
         skid_d     = '0;
         skid_vld_d = 1'b0;
      end

      in_rdy_d = !skid_vld_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         in_rdy_q   <= 1'b1;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         in_rdy_q   <= in_rdy_d;
      end
   end

   assign in_rdy    = in_rdy_q;
   assign out_vld   = out_vld_q;
   assign wb_en     = out_q.wb_en;
   assign wb_rd     = out_q.wb_rd;
   assign wb_data   = out_q.wb_data;
   assign br_vld    = out_q.br_vld;
   assign br_taken  = out_q.br_taken;
   assign br_target = out_q.br_target;

   // A killed cycle must never steer fetch, even if the handshake completes.
   assign redirect = out_vld_q && out_rdy && out_q.br_vld && out_q.br_taken && !flush && !rst;

endmodule

// File: tb/tb_zion_rvi_addsub_resolve_stage.sv
// tb/tb_zion_rvi_addsub_resolve_stage.sv - self-checking bench for the add/sub resolve stage
module tb_zion_rvi_addsub_resolve_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_vld;
   logic        in_rdy;
   logic [2:0]  in_op;
   logic [31:0] in_rslt;
   logic        in_lt;
   logic [4:0]  in_rd;
   logic [31:0] in_pc;
   logic [31:0] in_imm;
   logic        out_vld;
   logic        out_rdy;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        br_vld;
   logic        br_taken;
   logic [31:0] br_target;
   logic        redirect;

   zion_rvi_addsub_resolve_stage #(.XLEN(32), .REG_IDX_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op), .in_rslt(in_rslt),
      .in_lt(in_lt), .in_rd(in_rd), .in_pc(in_pc), .in_imm(in_imm),
      .out_vld(out_vld), .out_rdy(out_rdy), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .br_vld(br_vld), .br_taken(br_taken),
      .br_target(br_target), .redirect(redirect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        wb_en;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        br;
      logic        taken;
      logic [31:0] target;
   } ent_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rslt;
      logic        lt;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        ewb;
      logic [4:0]  erd;
      logic [31:0] edata;
      logic        ebr;
      logic        etk;
      logic [31:0] etgt;
   } vec_t;

   ent_t exp_q[$];
   vec_t vt[10];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic ent_t model(input logic [2:0] op, input logic [31:0] rslt, input logic lt,
                                  input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm);
      ent_t e;
      e = '0;
      e.target = pc + imm;
      if (op <= 3'd3) begin
         e.wb_en   = (rd != 0);
         e.wb_rd   = rd;
         e.wb_data = (op >= 3'd2) ? {31'b0, lt} : rslt;
      end else begin
         e.br = 1'b1;
         case (op)
            3'd4:    e.taken = (rslt == 0);
            3'd5:    e.taken = (rslt != 0);
            3'd6:    e.taken = lt;
            default: e.taken = !lt;
         endcase
      end
      return e;
   endfunction

   task automatic set_in(input logic [2:0] op, input logic [31:0] rslt, input logic lt,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm);
      in_op = op; in_rslt = rslt; in_lt = lt; in_rd = rd; in_pc = pc; in_imm = imm;
   endtask

   // Called at a negedge with inputs applied; checks against the queue model, then clocks once.
   task automatic step();
      ent_t h;
      bit   mv, acc, drn, exp_redir;
      #1;
      h  = '0;
      mv = (exp_q.size() > 0);
      chk("in_rdy", in_rdy, exp_q.size() < 2);
      chk("out_vld", out_vld, mv);
      if (mv) begin
         h = exp_q[0];
         chk("wb_en", wb_en, h.wb_en);
         chk("br_vld", br_vld, h.br);
         chk("br_taken", br_taken, h.taken);
         chk("br_target", br_target, h.target);
         if (!h.br) begin
            chk("wb_rd", wb_rd, h.wb_rd);
            chk("wb_data", wb_data, h.wb_data);
         end
      end
      exp_redir = mv && out_rdy && h.br && h.taken && !flush && !rst;
      chk("redirect", redirect, exp_redir);
      acc = in_vld && (exp_q.size() < 2);
      drn = mv && out_rdy;
      if (rst || flush) exp_q.delete();
      else begin
         if (drn) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(model(in_op, in_rslt, in_lt, in_rd, in_pc, in_imm));
      end
      @(negedge clk);
   endtask

   initial begin
      vt[0] = '{3'd0, 32'h1234, 1'b0, 5'd5, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 32'h0};
      vt[1] = '{3'd2, 32'hDEAD, 1'b1, 5'd3, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1, 1'b0, 1'b0, 32'h0};
      vt[2] = '{3'd3, 32'h5, 1'b0, 5'd7, 32'h0, 32'h0, 1'b1, 5'd7, 32'h0, 1'b0, 1'b0, 32'h0};
      vt[3] = '{3'd0, 32'h55, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h55, 1'b0, 1'b0, 32'h0};
      vt[4] = '{3'd4, 32'h0, 1'b0, 5'd9, 32'h100, 32'hFFFF_FFF8, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'hF8};
      vt[5] = '{3'd5, 32'h0, 1'b0, 5'd9, 32'h100, 32'hFFFF_FFF8, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'hF8};
      vt[6] = '{3'd7, 32'h3, 1'b1, 5'd9, 32'h100, 32'hFFFF_FFF8, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'hF8};
      vt[7] = '{3'd6, 32'h9, 1'b1, 5'd1, 32'hFFFF_FFF0, 32'h20, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h10};
      vt[8] = '{3'd7, 32'h9, 1'b0, 5'd1, 32'h200, 32'h10, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h210};
      vt[9] = '{3'd5, 32'h7, 1'b0, 5'd1, 32'h300, 32'h4, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h304};

      rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
      set_in(3'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_vld", out_vld, 1'b0);
      chk("rst_in_rdy", in_rdy, 1'b1);
      chk("rst_redirect", redirect, 1'b0);
      chk("rst_wb_en", wb_en, 1'b0);
      chk("rst_br_vld", br_vld, 1'b0);
      chk("rst_br_taken", br_taken, 1'b0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_br_target", br_target, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Table vectors, one entry at a time with downstream always ready.
      out_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(vt[i].op, vt[i].rslt, vt[i].lt, vt[i].rd, vt[i].pc, vt[i].imm);
         in_vld = 1'b1;
         step();
         in_vld = 1'b0;
         #1;
         chk($sformatf("tbl%0d_out_vld", i), out_vld, 1'b1);
         chk($sformatf("tbl%0d_wb_en", i), wb_en, vt[i].ewb);
         chk($sformatf("tbl%0d_br_vld", i), br_vld, vt[i].ebr);
         chk($sformatf("tbl%0d_br_taken", i), br_taken, vt[i].etk);
         chk($sformatf("tbl%0d_br_target", i), br_target, vt[i].etgt);
         chk($sformatf("tbl%0d_redirect", i), redirect, vt[i].ebr && vt[i].etk);
         if (!vt[i].ebr) begin
            chk($sformatf("tbl%0d_wb_rd", i), wb_rd, vt[i].erd);
            chk($sformatf("tbl%0d_wb_data", i), wb_data, vt[i].edata);
         end
         step();
      end

      // Backpressure: A, B, C back to back while stalled.
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      set_in(3'd0, 32'hA, 1'b0, 5'd1, 32'h0, 32'h0); step();
      set_in(3'd0, 32'hB, 1'b0, 5'd2, 32'h0, 32'h0); step();
      set_in(3'd0, 32'hC, 1'b0, 5'd3, 32'h0, 32'h0);
      #1;
      chk("bp_in_rdy_low", in_rdy, 1'b0);
      repeat (3) step();
      #1;
      chk("bp_hold_a", wb_data, 32'hA);
      out_rdy = 1'b1;
      step();
      #1;
      chk("bp_order_b", wb_data, 32'hB);
      step();
      in_vld = 1'b0;
      #1;
      chk("bp_order_c", wb_data, 32'hC);
      step();
      #1;
      chk("bp_empty", out_vld, 1'b0);

      // Flush under stall with a taken branch on the output and the skid full.
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      set_in(3'd4, 32'h0, 1'b0, 5'd0, 32'h40, 32'h8); step();
      set_in(3'd5, 32'h1, 1'b0, 5'd0, 32'h80, 32'h8); step();
      set_in(3'd0, 32'h99, 1'b0, 5'd6, 32'h0, 32'h0);
      flush   = 1'b1;
      out_rdy = 1'b1;
      step();
      flush  = 1'b0;
      in_vld = 1'b0;
      #1;
      chk("fl_out_vld", out_vld, 1'b0);
      chk("fl_in_rdy", in_rdy, 1'b1);
      chk("fl_br_vld", br_vld, 1'b0);
      repeat (3) step();

      // Reset mid-stall, then first post-reset entry after one cycle.
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      set_in(3'd4, 32'h0, 1'b0, 5'd0, 32'h40, 32'h8); step();
      set_in(3'd6, 32'h0, 1'b1, 5'd0, 32'h50, 32'h8); step();
      rst     = 1'b1;
      out_rdy = 1'b1;
      step();
      rst    = 1'b0;
      in_vld = 1'b0;
      #1;
      chk("rs_out_vld", out_vld, 1'b0);
      chk("rs_in_rdy", in_rdy, 1'b1);
      chk("rs_br_vld", br_vld, 1'b0);
      chk("rs_br_taken", br_taken, 1'b0);
      chk("rs_redirect", redirect, 1'b0);
      set_in(3'd0, 32'h77, 1'b0, 5'd4, 32'h0, 32'h0);
      in_vld = 1'b1;
      step();
      in_vld = 1'b0;
      #1;
      chk("rs_first_vld", out_vld, 1'b1);
      chk("rs_first_data", wb_data, 32'h77);
      step();

      // rst and flush together.
      in_vld  = 1'b1;
      out_rdy = 1'b0;
      set_in(3'd4, 32'h0, 1'b0, 5'd0, 32'h10, 32'h10); step();
      rst = 1'b1; flush = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0; in_vld = 1'b0;
      #1;
      chk("rf_out_vld", out_vld, 1'b0);
      chk("rf_in_rdy", in_rdy, 1'b1);

      // Randomized traffic against the queue model.
      for (int c = 0; c < 3000; c++) begin
         in_vld  = ($urandom % 4) != 0;
         out_rdy = ($urandom % 3) != 0;
         flush   = ($urandom % 50) == 0;
         set_in(3'($urandom % 8), (($urandom % 4) == 0) ? 32'h0 : $urandom, 1'($urandom % 2),
                (($urandom % 4) == 0) ? 5'd0 : 5'($urandom % 32), $urandom, $urandom);
         step();
      end
      flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/zion_rvi_addsub_resolve_stage.md
Name: zion_rvi_addsub_resolve_stage

Overview:
- Pipeline stage directly downstream of the Rvi add/sub execute unit and its less-than logic.
- Registers each add/sub result and converts it into either a writeback (ADD/SUB/SLT/SLTU) or a branch decision with a redirect target (BEQ/BNE/BLT[U]/BGE[U]).
- Decouples the execute stage from writeback/fetch through a valid/ready interface with a 2-entry skid buffer, so upstream sees a fully registered ready.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- REG_IDX_W, 5, destination register index width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of all held and incoming entries.
- in_vld  input  1  upstream entry valid.
- in_rdy  output  1  stage can accept; registered.
- in_op  input  3  0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 BEQ, 5 BNE, 6 BLT/BLTU, 7 BGE/BGEU.
- in_rslt  input  XLEN  add/sub result (subtract for ops 1-7).
- in_lt  input  1  less-than from the execute unit; signedness already applied upstream.
- in_rd  input  REG_IDX_W  destination register index.
- in_pc  input  XLEN  instruction PC.
- in_imm  input  XLEN  sign-extended branch offset.
- out_vld  output  1  result valid.
- out_rdy  input  1  downstream accepts.
- wb_en  output  1  register write required.
- wb_rd  output  REG_IDX_W  write index.
- wb_data  output  XLEN  write data.
- br_vld  output  1  entry is a branch.
- br_taken  output  1  branch condition true.
- br_target  output  XLEN  in_pc + in_imm, modulo 2^XLEN.
- redirect  output  1  single-cycle pulse when a taken branch is handed off.

Behaviour:
- Reset: out_vld=0, in_rdy=1, redirect=0, wb_en=0, br_vld=0, br_taken=0; data outputs 0; both buffer entries empty.
- Resolution is combinational on the input side; the resolved fields are stored.
  - ADD/SUB: wb_data=in_rslt.
  - SLT/SLTU: wb_data = zero-extended in_lt.
  - wb_en = (op<=3) && (in_rd!=0).
  - Branches: br_vld=1, wb_en=0, eq=(in_rslt==0).
  - Taken condition: BEQ eq; BNE !eq; op 6 in_lt; op 7 !in_lt.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 when the output register is free.
- Buffering:
  - Output register plus one skid entry.
  - Accept = in_vld && in_rdy.
  - in_rdy(next) = !(skid full after this cycle's updates).
  - With out_vld=1 and out_rdy=0, a new accept goes to the skid entry.
  - When the output register drains, the skid entry moves to output in the same cycle. An accept in that same cycle refills the skid entry.
  - Ordering is strictly preserved. No entry is dropped or duplicated.
- Output values are held stable while out_vld && !out_rdy.
- redirect = out_vld && out_rdy && br_vld && br_taken. It is asserted exactly once per taken branch and is combinational from the output register and out_rdy.
- flush:
  - Next cycle: out_vld=0, skid empty, in_rdy=1.
  - An entry presented in the flush cycle is discarded.
  - redirect is forced 0 in the flush cycle.
- rst and flush in the same cycle: reset state.
- Reset mid-stall: all held entries are discarded and no redirect follows.
- Wrap-around: br_target is computed at XLEN width with carry discarded. Example XLEN=32: 0xFFFF_FFF0 + 0x20 = 0x0000_0010.
- XLEN=64: SLT data is zero-extended to 64 bits.

Test Plan:
- ADD stream, out_rdy=1:
  - in_op=0, in_rslt=0x1234, in_rd=5 -> next cycle out_vld=1, wb_en=1, wb_rd=5, wb_data=0x1234.
  - One result per cycle; in_rdy stays 1.
- SLT/SLTU and x0:
  - op2 with in_lt=1, rd=3 -> wb_data=1.
  - op3 with in_lt=0 -> wb_data=0.
  - op0 with rd=0 -> wb_en=0, out_vld=1.
- Branches, out_rdy=1, in_pc=0x100, in_imm=0xFFFF_FFF8:
  - BEQ with in_rslt=0 -> br_taken=1, br_target=0xF8, redirect=1 for one cycle.
  - BNE with in_rslt=0 -> br_taken=0, redirect=0.
  - BGE with in_lt=1 -> taken=0.
- Backpressure:
  - Hold out_rdy=0 and send A, B, C back to back -> A on output, B in skid, in_rdy=0 from the cycle after B is accepted, C held upstream.
  - Release out_rdy -> A, B, C delivered in order with outputs stable while stalled.
- Flush under stall:
  - Output holds a taken branch, skid full, out_rdy=0; assert flush with in_vld=1 -> next cycle out_vld=0, in_rdy=1.
  - No redirect ever issued; the flush-cycle input is absent.
- Reset:
  - Assert rst with both entries full -> next cycle all outputs at reset values.
  - First post-reset accepted entry appears after 1 cycle.
